// File: rtl/imm_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder_pkg
// Description : Shared definitions for the immediate encoder. These include the
//               immsrc codes (the same ones the core's immediate extender
//               uses), the opcodes used to expand LI, the NOP word and the
//               encoder state type.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_encoder_pkg;

  // immsrc encodings. 3'b110 and 3'b111 are illegal.
  localparam logic [2:0] IMM_I  = 3'b000;
  localparam logic [2:0] IMM_S  = 3'b001;
  localparam logic [2:0] IMM_B  = 3'b010;
  localparam logic [2:0] IMM_U  = 3'b011;
  localparam logic [2:0] IMM_J  = 3'b100;
  localparam logic [2:0] IMM_LI = 3'b101;

  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [2:0] F3_ADDI = 3'b000;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,  // nothing held
    ST_HOLD      = 2'd1,  // one final beat held
    ST_HOLD_PEND = 2'd2   // LUI beat held, ADDI waiting in the pend register
  } state_e;

  // True when v, read as a signed 32-bit value, fits in a signed field whose
  // sign bit sits at position msb. In that case bits [31:msb] are all equal.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic [31:0] s;
    s = 32'($signed(v) >>> msb);
    return (s == '0) || (s == '1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder_if
// Description : Request/response handshake bundle for imm_encoder.
//   Request  : in_valid, in_ready, in_immsrc[2:0], in_base[31:0], in_imm[31:0]
//   Response : out_valid, out_ready, out_instr[31:0], out_err, out_last
//   master   : the requester and consumer (drives the request side and out_ready)
//   slave    : the encoder
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_immsrc;
  logic [31:0] in_base;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic        out_last;

  modport master (
    output in_valid, in_immsrc, in_base, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err, out_last
  );

  modport slave (
    input  in_valid, in_immsrc, in_base, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err, out_last
  );
endinterface
`default_nettype wire

// File: rtl/imm_encoder_pack.sv
`default_nettype none
// ============================================================================
// Module      : imm_pack
// Description : Combinational packer. It places a signed immediate into the
//               immediate bit positions of a base instruction (the inverse of
//               the immediate extender) and reports whether the value fits.
//   immsrc[2:0] in  : format (I/S/B/U/J); any other code gives ok=0
//   base[31:0]  in  : instruction with non-immediate fields filled
//   imm[31:0]   in  : signed immediate
//   word[31:0]  out : base with the immediate fields replaced
//   ok          out : immediate is encodable in the selected format
// Revision    : 1.0 - initial release
// ============================================================================
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  immsrc,
  input  logic [31:0] base,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        ok
);

  // The concatenations keep only the non-immediate bits of base. That clears
  // the immediate positions before the new fields go in.
  always_comb begin
    word = base;
    ok   = 1'b0;
    case (immsrc)
      IMM_I: begin
        word = {imm[11:0], base[19:0]};
        ok   = fits_signed(imm, 11);
      end
      IMM_S: begin
        word = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        ok   = fits_signed(imm, 11);
      end
      IMM_B: begin
        word = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        ok   = fits_signed(imm, 12) && !imm[0];
      end
      IMM_U: begin
        word = {imm[31:12], base[11:0]};
        ok   = (imm[11:0] == 12'h000);
      end
      IMM_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        ok   = fits_signed(imm, 20) && !imm[0];
      end
      default: begin
        word = base;
        ok   = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder
// Description : Encodes an immediate into an instruction word for the
//               debug/boot instruction-injection path. Range errors give a
//               NOP with out_err set. The LI pseudo-op expands to LUI, ADDI,
//               or LUI followed by ADDI. There is one registered output stage,
//               plus a pend register that holds the second beat of an LI.
//   clk         in  : clock, rising edge
//   reset       in  : asynchronous, active-high
//   bus         slave modport of imm_encoder_if (valid/ready request and response)
// Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter logic [31:0] RESET_NOP = NOP_INSTR
) (
  input  logic           clk,
  input  logic           reset,
  imm_encoder_if.slave   bus
);

  state_e      state;
  logic [31:0] instr_reg;
  logic        err_reg;
  logic        last_reg;
  logic [31:0] pend_reg;

  logic        accept;

  // Fields used to expand LI
  logic [4:0]  li_rd;
  logic [11:0] li_lo;
  logic [19:0] li_hi;
  logic        li_small;
  logic [31:0] lui_word,  addi_word,  main_word;
  logic        lui_ok,    addi_ok,    main_ok;

  // Next beat decoded from the current request
  logic [31:0] next_instr;
  logic        next_err;
  logic        next_last;
  logic        next_two;

  assign bus.in_ready  = !reset &&
                         ((state == ST_EMPTY) || ((state == ST_HOLD) && bus.out_ready));
  assign bus.out_valid = (state != ST_EMPTY);
  assign bus.out_instr = instr_reg;
  assign bus.out_err   = err_reg;
  assign bus.out_last  = last_reg;

  assign accept = bus.in_valid && bus.in_ready;

  assign li_rd    = bus.in_base[11:7];
  assign li_lo    = bus.in_imm[11:0];
  // (imm + 0x800) >> 12. The carry out of the low 12 bits is just imm[11].
  // The add wraps modulo 2^20, which matches the mod-2^32 sum.
  assign li_hi    = bus.in_imm[31:12] + {19'd0, bus.in_imm[11]};
  assign li_small = fits_signed(bus.in_imm, 11);

  imm_pack u_pack_main (
    .immsrc (bus.in_immsrc),
    .base   (bus.in_base),
    .imm    (bus.in_imm),
    .word   (main_word),
    .ok     (main_ok)
  );

  imm_pack u_pack_lui (
    .immsrc (IMM_U),
    .base   ({20'd0, li_rd, OP_LUI}),
    .imm    ({li_hi, 12'd0}),
    .word   (lui_word),
    .ok     (lui_ok)
  );

  // A small LI is ADDI rd,x0,lo. The second half of a pair is ADDI rd,rd,lo.
  imm_pack u_pack_addi (
    .immsrc (IMM_I),
    .base   ({12'd0, (li_small ? 5'd0 : li_rd), F3_ADDI, li_rd, OP_IMM}),
    .imm    ({{20{li_lo[11]}}, li_lo}),
    .word   (addi_word),
    .ok     (addi_ok)
  );

  always_comb begin
    next_instr = RESET_NOP;
    next_err   = 1'b1;
    next_last  = 1'b1;
    next_two   = 1'b0;
    case (bus.in_immsrc)
      IMM_I, IMM_S, IMM_B, IMM_U, IMM_J: begin
        if (main_ok) begin
          next_instr = main_word;
          next_err   = 1'b0;
        end
      end
      IMM_LI: begin
        // Both sub-words are always in range by construction, so LI never errors
        if (lui_ok && addi_ok) begin
          next_err = 1'b0;
          if (li_small) begin
            next_instr = addi_word;
          end else if (li_lo == 12'h000) begin
            next_instr = lui_word;
          end else begin
            next_instr = lui_word;
            next_last  = 1'b0;
            next_two   = 1'b1;
          end
        end
      end
      default: begin
        next_instr = RESET_NOP;
        next_err   = 1'b1;
      end
    endcase
  end

  // An accept can only happen in EMPTY, or in HOLD while the held beat is
  // being consumed. In both cases the new beat replaces the output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_EMPTY;
      instr_reg <= RESET_NOP;
      err_reg   <= 1'b0;
      last_reg  <= 1'b0;
      pend_reg  <= RESET_NOP;
    end else if (accept) begin
      state     <= next_two ? ST_HOLD_PEND : ST_HOLD;
      instr_reg <= next_instr;
      err_reg   <= next_err;
      last_reg  <= next_last;
      pend_reg  <= addi_word;
    end else if ((state == ST_HOLD) && bus.out_ready) begin
      state     <= ST_EMPTY;
      instr_reg <= RESET_NOP;
      err_reg   <= 1'b0;
      last_reg  <= 1'b0;
    end else if ((state == ST_HOLD_PEND) && bus.out_ready) begin
      state     <= ST_HOLD;
      instr_reg <= pend_reg;
      err_reg   <= 1'b0;
      last_reg  <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_encoder
// Description : Self-checking bench for imm_encoder. It applies a table of
//               directed vectors, then runs hand-written sequences for
//               backpressure, streaming and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic reset;
  imm_encoder_if bus_if ();

  imm_encoder #(.RESET_NOP(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  src;
    logic [31:0] base;
    logic [31:0] imm;
    logic        two;
    logic        err;
    logic [31:0] w1;
    logic [31:0] w2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic [2:0] s, input logic [31:0] b,
                     input logic [31:0] i, input logic t, input logic e,
                     input logic [31:0] a, input logic [31:0] c);
    vec_t v;
    v.name = n; v.src = s; v.base = b; v.imm = i;
    v.two = t; v.err = e; v.w1 = a; v.w2 = c;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] s, input logic [31:0] b, input logic [31:0] i);
    bus_if.in_valid  = 1'b1;
    bus_if.in_immsrc = s;
    bus_if.in_base   = b;
    bus_if.in_imm    = i;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  logic [31:0] s_imm [4];
  logic [31:0] s_exp [4];

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_immsrc = 3'b000;
    bus_if.in_base   = 32'h0;
    bus_if.in_imm    = 32'h0;
    bus_if.out_ready = 1'b1;
    reset = 1'b1;

    // name        src     base          imm           two  err  w1            w2
    add("i_m1",    IMM_I,  32'h00000293, 32'hFFFFFFFF, 0,   0,   32'hFFF00293, 32'h0);
    add("i_max",   IMM_I,  32'h00000293, 32'h000007FF, 0,   0,   32'h7FF00293, 32'h0);
    add("i_min",   IMM_I,  32'h00000293, 32'hFFFFF800, 0,   0,   32'h80000293, 32'h0);
    add("i_ovf",   IMM_I,  32'h00000293, 32'h00000800, 0,   1,   NOP,          32'h0);
    add("i_unf",   IMM_I,  32'h00000293, 32'hFFFFF7FF, 0,   1,   NOP,          32'h0);
    add("s_mask",  IMM_S,  32'hFE512FA3, 32'h00000008, 0,   0,   32'h00512423, 32'h0);
    add("s_m4",    IMM_S,  32'h00512023, 32'hFFFFFFFC, 0,   0,   32'hFE512E23, 32'h0);
    add("s_unf",   IMM_S,  32'h00512023, 32'hFFFFF7FF, 0,   1,   NOP,          32'h0);
    add("b_max",   IMM_B,  32'h00000063, 32'h00000FFE, 0,   0,   32'h7E000FE3, 32'h0);
    add("b_min",   IMM_B,  32'h00000063, 32'hFFFFF000, 0,   0,   32'h80000063, 32'h0);
    add("b_m2",    IMM_B,  32'h00000063, 32'hFFFFFFFE, 0,   0,   32'hFE000FE3, 32'h0);
    add("b_odd",   IMM_B,  32'h00000063, 32'h00000003, 0,   1,   NOP,          32'h0);
    add("b_ovf",   IMM_B,  32'h00000063, 32'h00001000, 0,   1,   NOP,          32'h0);
    add("u_ok",    IMM_U,  32'h000002B7, 32'h12345000, 0,   0,   32'h123452B7, 32'h0);
    add("u_low",   IMM_U,  32'h000002B7, 32'h12345001, 0,   1,   NOP,          32'h0);
    add("j_8",     IMM_J,  32'h000000EF, 32'h00000008, 0,   0,   32'h008000EF, 32'h0);
    add("j_odd",   IMM_J,  32'h000000EF, 32'h00000003, 0,   1,   NOP,          32'h0);
    add("j_max",   IMM_J,  32'h000000EF, 32'h000FFFFE, 0,   0,   32'h7FFFF0EF, 32'h0);
    add("j_min",   IMM_J,  32'h000000EF, 32'hFFF00000, 0,   0,   32'h800000EF, 32'h0);
    add("j_ovf",   IMM_J,  32'h000000EF, 32'h00100000, 0,   1,   NOP,          32'h0);
    add("src110",  3'b110, 32'h00000293, 32'h00000000, 0,   1,   NOP,          32'h0);
    add("src111",  3'b111, 32'h00000293, 32'h00000000, 0,   1,   NOP,          32'h0);
    add("li_two",  IMM_LI, 32'hFFFFF500, 32'h12345FFF, 1,   0,   32'h12346537, 32'hFFF50513);
    add("li_lui",  IMM_LI, 32'h00000080, 32'h00001000, 0,   0,   32'h000010B7, 32'h0);
    add("li_5",    IMM_LI, 32'h00000080, 32'h00000005, 0,   0,   32'h00500093, 32'h0);
    add("li_m1",   IMM_LI, 32'h00000080, 32'hFFFFFFFF, 0,   0,   32'hFFF00093, 32'h0);
    add("li_top",  IMM_LI, 32'h00000080, 32'h7FFFF800, 1,   0,   32'h800000B7, 32'h80008093);
    add("li_m2049",IMM_LI, 32'h00000080, 32'hFFFFF7FF, 1,   0,   32'hFFFFF0B7, 32'h7FF08093);
    add("li_m4096",IMM_LI, 32'h00000080, 32'hFFFFF000, 0,   0,   32'hFFFFF0B7, 32'h0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst_ready", 32'(bus_if.in_ready),  32'd0);
    chk("rst_instr", bus_if.out_instr,      NOP);
    chk("rst_err",   32'(bus_if.out_err),   32'd0);
    chk("rst_last",  32'(bus_if.out_last),  32'd0);
    reset = 1'b0;

    // Table-driven vectors with out_ready held high
    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].src, vecs[k].base, vecs[k].imm);
      chk({vecs[k].name, "/in_ready"}, 32'(bus_if.in_ready), 32'd1);
      @(posedge clk);
      #1 bus_if.in_valid = 1'b0;
      @(negedge clk);
      chk({vecs[k].name, "/valid"}, 32'(bus_if.out_valid), 32'd1);
      chk({vecs[k].name, "/instr"}, bus_if.out_instr, vecs[k].w1);
      chk({vecs[k].name, "/err"},   32'(bus_if.out_err),  32'(vecs[k].err));
      chk({vecs[k].name, "/last"},  32'(bus_if.out_last), 32'(!vecs[k].two));
      if (vecs[k].two) begin
        chk({vecs[k].name, "/ready_mid"}, 32'(bus_if.in_ready), 32'd0);
        @(negedge clk);
        chk({vecs[k].name, "/instr2"}, bus_if.out_instr, vecs[k].w2);
        chk({vecs[k].name, "/last2"},  32'(bus_if.out_last), 32'd1);
        chk({vecs[k].name, "/err2"},   32'(bus_if.out_err),  32'd0);
      end
    end
    @(negedge clk);
    chk("drain_valid", 32'(bus_if.out_valid), 32'd0);
    chk("drain_instr", bus_if.out_instr, NOP);

    // Backpressure mid-LI, with a competing request held on the input
    s_imm = '{32'h00000007, 32'hFFFFFFF9, 32'h00000064, 32'h000007FF};
    s_exp = '{32'h00700293, 32'hFF900293, 32'h06400293, 32'h7FF00293};
    bus_if.out_ready = 1'b0;
    drive(IMM_LI, 32'h00000500, 32'h12345FFF);
    @(posedge clk);
    #1 drive(IMM_I, 32'h00000293, s_imm[0]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_instr", bus_if.out_instr, 32'h12346537);
      chk("bp_last",  32'(bus_if.out_last), 32'd0);
      chk("bp_ready", 32'(bus_if.in_ready), 32'd0);
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_addi",  bus_if.out_instr, 32'hFFF50513);
    chk("bp_last2", 32'(bus_if.out_last), 32'd1);
    chk("bp_ready2", 32'(bus_if.in_ready), 32'd1);
    // The held I request streams in now, followed by three more, one per cycle
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 3) drive(IMM_I, 32'h00000293, s_imm[k+1]);
      else       bus_if.in_valid = 1'b0;
      @(negedge clk);
      chk("stream_valid", 32'(bus_if.out_valid), 32'd1);
      chk("stream_instr", bus_if.out_instr, s_exp[k]);
    end
    @(negedge clk);
    chk("stream_empty", 32'(bus_if.out_valid), 32'd0);

    // Asynchronous reset while in HOLD_PEND
    bus_if.out_ready = 1'b0;
    drive(IMM_LI, 32'h00000500, 32'h12345FFF);
    @(posedge clk);
    #1 bus_if.in_valid = 1'b0;
    @(negedge clk);
    chk("ar_pre_instr", bus_if.out_instr, 32'h12346537);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(bus_if.out_valid), 32'd0);
    chk("ar_ready", 32'(bus_if.in_ready),  32'd0);
    chk("ar_instr", bus_if.out_instr, NOP);
    chk("ar_last",  32'(bus_if.out_last), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_if.out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("ar_no_stale", 32'(bus_if.out_valid), 32'd0);
    end
    drive(IMM_I, 32'h00000293, 32'h00000005);
    @(posedge clk);
    #1 bus_if.in_valid = 1'b0;
    @(negedge clk);
    chk("ar_new_instr", bus_if.out_instr, 32'h00500293);
    chk("ar_new_last",  32'(bus_if.out_last), 32'd1);
    @(negedge clk);
    chk("ar_end_valid", 32'(bus_if.out_valid), 32'd0);
    chk("ar_end_instr", bus_if.out_instr, NOP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the core's immediate extender: packs a 32-bit signed immediate into an instruction word according to immsrc.
- Range-checks the immediate and flags values that cannot be encoded.
- Expands a load-immediate (LI) pseudo-op into LUI/ADDI.
- Feeds the debug/boot instruction-injection path ahead of imem. Valid/ready on both sides, one registered output stage.

Parameters:
- RESET_NOP, 32'h0000_0013, word driven on out_instr when empty or on error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&&in_ready.
- in_immsrc  in  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 LI, 110/111 illegal.
- in_base  in  32  instruction with all non-immediate fields filled; immediate bit positions ignored (masked).
- in_imm  in  32  signed immediate (U: full value, low 12 bits must be zero).
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer ready.
- out_instr  out  32  encoded instruction.
- out_err  out  1  immediate not encodable; out_instr=RESET_NOP.
- out_last  out  1  final beat of this request.

Behaviour:
- Reset (async, reset=1): state EMPTY, out_valid=0, out_instr=RESET_NOP, out_err=0, out_last=0, in_ready=0 while reset high. Any pending second beat is discarded.
- States:
  - EMPTY: nothing held.
  - HOLD: one final beat held.
  - HOLD_PEND: LUI beat held, ADDI pending in a pend register.
- in_ready = (state==EMPTY) || (state==HOLD && out_ready). Never asserted in HOLD_PEND.
- Latency: accept at edge N → out_valid=1 after edge N. Full throughput for single-beat requests.
- Output stability: out_instr, out_err and out_last are stable while out_valid && !out_ready.
- Transitions:
  - EMPTY, accept → HOLD, or HOLD_PEND for a two-beat LI.
  - HOLD, out_ready && no accept → EMPTY.
  - HOLD, out_ready && accept → HOLD or HOLD_PEND (new beat).
  - HOLD_PEND, out_ready → HOLD, loading the ADDI beat from pend.
- Masking: fields are placed into in_base after clearing the type's immediate positions.
  - I: [31:20]=imm[11:0]; legal range −2048..2047.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]; legal range −2048..2047.
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]; legal range −4096..4094, imm[0]=0.
  - U: [31:12]=imm[31:12]; imm[11:0] must be 0.
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]; legal range −2^20..2^20−2, imm[0]=0.
- LI (rd=in_base[11:7]; other base fields ignored):
  - lo = imm[11:0]; hi = (imm + 32'h800)[31:12], with wrap mod 2^32.
  - imm in −2048..2047: single beat, ADDI rd,x0,lo.
  - else if lo==0: single beat, LUI rd,hi.
  - else: LUI rd,hi (out_last=0), then ADDI rd,rd,lo (out_last=1).
  - LI is never an error.
- Error cases: out-of-range or misaligned immediate, or illegal immsrc. Result is a single beat with out_err=1, out_instr=RESET_NOP, out_last=1.
- All range checks are done on the full 32-bit signed in_imm.

Decomposition:
- Shared package:
  - immsrc encodings (shared with the extender).
  - OP_LUI 7'b0110111, OP_IMM 7'b0010011, funct3 ADDI 3'b000.
  - RESET_NOP.
  - State enum.
- Sub-module imm_pack (combinational):
  - Inputs: immsrc, base, imm.
  - Outputs: packed word, ok flag.
  - Reused for the ADDI/LUI words of LI.
- imm_encoder holds the FSM, the output register and the pend register.

Test Plan:
- I: base 0x0000_0293 (addi x5,x0), imm −1 → one beat 0xFFF00293, err=0, last=1, appearing one cycle after accept.
- J: base 0x0000_00EF, imm 8 → 0x008000EF. Same base with imm 3 → err=1, out_instr=0x00000013.
- LI x10, imm 0x12345FFF → beat 1: 0x12346537, last=0. Beat 2: 0xFFF50513, last=1. in_ready=0 between the two beats.
- LI x1, imm 0x00001000 → single beat 0x000010B7, last=1. LI x1, imm 5 → 0x00500093.
- Backpressure: hold out_ready=0 for 3 cycles mid-LI → out_instr held at 0x12346537, no input accepted. Then stream 4 I-type requests back-to-back with out_ready=1 → 1 beat per cycle.
- Reset asserted in HOLD_PEND (asynchronously, mid-cycle) → out_valid drops without waiting for a clock edge. After release: EMPTY, first new request encoded correctly, stale ADDI never emitted.
